// File: rtl/posit_round_rne_if.sv
// Handshake and data bundle between the normalise/shift stage and the posit rounding stage.
// The master drives the operands and start; the slave returns the rounded fields.
interface posit_round_rne_if #(
  parameter int N   = 32,
  parameter int ES  = 3,
  parameter int MW  = 64,
  parameter int K_W = 6
);
  logic                  start;
  logic                  rnd_mode;
  logic [MW-1:0]         shifted_mantissa;
  logic signed [K_W-1:0] k_out;
  logic                  sign_out;
  logic [ES-1:0]         exp_out;
  logic [N-1:0]          mantissa_out;
  logic signed [K_W-1:0] k_final;
  logic [ES-1:0]         exp_final;
  logic                  sign_final;
  logic                  inexact;
  logic                  overflow;
  logic                  busy;
  logic                  done;

  modport master (
    output start, rnd_mode, shifted_mantissa, k_out, sign_out, exp_out,
    input  mantissa_out, k_final, exp_final, sign_final, inexact, overflow, busy, done
  );

  modport slave (
    input  start, rnd_mode, shifted_mantissa, k_out, sign_out, exp_out,
    output mantissa_out, k_final, exp_final, sign_final, inexact, overflow, busy, done
  );
endinterface

// File: rtl/posit_round_rne.sv
// Posit fraction rounding stage: sizes the fraction field from regime k and ES, truncates or
// rounds to nearest-even, and propagates the rounding carry into exponent and regime.
module posit_round_rne #(
  parameter int N   = 32,
  parameter int ES  = 3,
  parameter int MW  = 64,
  parameter int K_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  posit_round_rne_if.slave  bus
);
  localparam int FW    = MW - 2;
  localparam int NBT_W = $clog2(N);
  localparam logic signed [K_W-1:0] KMAX = K_W'(N - 2);
  localparam logic [ES-1:0] EMAX = {ES{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ROUND  = 3'd2,
    S_ADJUST = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state_r, state_nxt_s;

  logic [FW-1:0]         frac_r;
  logic signed [K_W-1:0] k_r;
  logic [ES-1:0]         exp_r;
  logic                  sign_r, rnd_r, carry_r, inx_r, ovf_r;
  logic [NBT_W-1:0]      nbt_r;
  logic [N-1:0]          fp_r;

  logic [N-1:0]          mant_out_r;
  logic signed [K_W-1:0] k_final_r;
  logic [ES-1:0]         exp_final_r;
  logic                  sign_final_r, inexact_r, overflow_r, busy_r, done_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state: only IDLE waits on start, the rest of the pipeline free-runs
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:   if (bus.start) state_nxt_s = S_LOAD; else state_nxt_s = S_IDLE;
      S_LOAD:   state_nxt_s = S_ROUND;
      S_ROUND:  state_nxt_s = S_ADJUST;
      S_ADJUST: state_nxt_s = S_DONE;
      S_DONE:   state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Fraction width from regime length
  logic signed [31:0] k_ext_s, rlen_s, nbt_raw_s;
  logic [NBT_W-1:0]   nbt_s;
  always_comb begin
    k_ext_s = 32'(k_r);
    if (k_ext_s >= 32'sd0) rlen_s = k_ext_s + 32'sd2;
    else                   rlen_s = 32'sd1 - k_ext_s;
    nbt_raw_s = 32'(N - 1 - ES) - rlen_s;
    if (nbt_raw_s < 32'sd0)             nbt_s = {NBT_W{1'b0}};
    else if (nbt_raw_s > 32'(N - 1))    nbt_s = NBT_W'(N - 1);
    else                                nbt_s = nbt_raw_s[NBT_W-1:0];
  end

  // Extraction and rounding; gpos is the guard bit position inside the fraction
  int             gpos_s;
  logic [FW-1:0]  shr_s, gsh_s, low_s;
  logic [N-1:0]   f_s, fp_s;
  logic [N:0]     sum_s;
  logic           g_s, s_s, lsb_s, inc_s, inx_s, c_s;
  always_comb begin
    gpos_s = FW - 1 - int'(nbt_r);
    shr_s  = frac_r >> (gpos_s + 1);
    gsh_s  = frac_r >> gpos_s;
    low_s  = frac_r << (FW - gpos_s);
    f_s    = shr_s[N-1:0];
    g_s    = gsh_s[0];
    s_s    = |low_s;
    if (nbt_r == {NBT_W{1'b0}}) lsb_s = 1'b0;
    else                        lsb_s = f_s[0];
    inx_s  = g_s | s_s;
    inc_s  = rnd_r & g_s & (s_s | lsb_s);
    sum_s  = {1'b0, f_s} + {{N{1'b0}}, inc_s};
    c_s    = sum_s[nbt_r];
    if (c_s) fp_s = {N{1'b0}};
    else     fp_s = sum_s[N-1:0];
  end

  // Carry into exponent, then regime; saturate at maxpos instead of passing KMAX
  logic signed [K_W-1:0] k_adj_s;
  logic [ES-1:0]         exp_adj_s;
  logic                  ovf_s;
  always_comb begin
    k_adj_s   = k_r;
    exp_adj_s = exp_r;
    ovf_s     = 1'b0;
    if (carry_r) begin
      if (exp_r != EMAX) begin
        exp_adj_s = exp_r + {{(ES-1){1'b0}}, 1'b1};
      end else if (k_r == KMAX) begin
        ovf_s = 1'b1;
      end else begin
        exp_adj_s = {ES{1'b0}};
        k_adj_s   = k_r + {{(K_W-1){1'b0}}, 1'b1};
      end
    end else begin
      ovf_s = 1'b0;
    end
  end

  // Datapath pipeline and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_r       <= {FW{1'b0}};
      k_r          <= {K_W{1'b0}};
      exp_r        <= {ES{1'b0}};
      sign_r       <= 1'b0;
      rnd_r        <= 1'b0;
      nbt_r        <= {NBT_W{1'b0}};
      fp_r         <= {N{1'b0}};
      carry_r      <= 1'b0;
      inx_r        <= 1'b0;
      ovf_r        <= 1'b0;
      mant_out_r   <= {N{1'b0}};
      k_final_r    <= {K_W{1'b0}};
      exp_final_r  <= {ES{1'b0}};
      sign_final_r <= 1'b0;
      inexact_r    <= 1'b0;
      overflow_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != S_IDLE);
      done_r <= (state_r == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            frac_r <= bus.shifted_mantissa[FW-1:0];
            k_r    <= bus.k_out;
            exp_r  <= bus.exp_out;
            sign_r <= bus.sign_out;
            rnd_r  <= bus.rnd_mode;
          end
        end
        S_LOAD:  nbt_r <= nbt_s;
        S_ROUND: begin
          fp_r    <= fp_s;
          carry_r <= c_s;
          inx_r   <= inx_s;
        end
        S_ADJUST: begin
          k_r   <= k_adj_s;
          exp_r <= exp_adj_s;
          ovf_r <= ovf_s;
        end
        S_DONE: begin
          mant_out_r   <= fp_r << (N - int'(nbt_r));
          k_final_r    <= k_r;
          exp_final_r  <= exp_r;
          sign_final_r <= sign_r;
          inexact_r    <= inx_r;
          overflow_r   <= ovf_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.mantissa_out = mant_out_r;
  assign bus.k_final      = k_final_r;
  assign bus.exp_final    = exp_final_r;
  assign bus.sign_final   = sign_final_r;
  assign bus.inexact      = inexact_r;
  assign bus.overflow     = overflow_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
endmodule

// File: tb/tb_posit_round_rne.sv
// Bench for posit_round_rne (N=32, ES=3, MW=64): vector table with a scoreboard queue,
// plus hand sequences for latency/busy, ignored starts, input stability and mid-run reset.
module tb_posit_round_rne;
  localparam int N = 32, ES = 3, MW = 64, K_W = 6;

  logic clk, rst_n;
  posit_round_rne_if #(.N(N), .ES(ES), .MW(MW), .K_W(K_W)) bus ();
  posit_round_rne #(.N(N), .ES(ES), .MW(MW), .K_W(K_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct {
    logic              rnd;
    logic [63:0]       mant;
    logic signed [5:0] k;
    logic              sgn;
    logic [2:0]        ex;
    logic [31:0]       e_mant;
    logic signed [5:0] e_k;
    logic [2:0]        e_exp;
    logic              e_inx;
    logic              e_ovf;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } sb_t;

  int   checks = 0, errors = 0, cyc = 0, done_cnt = 0, pushed = 0;
  sb_t  sbq[$];
  logic prev_done = 1'b0;
  vec_t vt[15];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done pops one expected result
  sb_t cur;
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      check("done_width", prev_done, 1'b0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        cur = sbq.pop_front();
        check("latency", 64'(cyc - cur.acc), 64'd4);
        check("busy_at_done", bus.busy, 1'b0);
        check("mantissa_out", bus.mantissa_out, cur.v.e_mant);
        check("k_final", bus.k_final, cur.v.e_k);
        check("exp_final", bus.exp_final, cur.v.e_exp);
        check("sign_final", bus.sign_final, cur.v.sgn);
        check("inexact", bus.inexact, cur.v.e_inx);
        check("overflow", bus.overflow, cur.v.e_ovf);
      end
    end
    prev_done = bus.done;
  end

  task automatic drive(input vec_t v);
    bus.rnd_mode         = v.rnd;
    bus.shifted_mantissa = v.mant;
    bus.k_out            = v.k;
    bus.sign_out         = v.sgn;
    bus.exp_out          = v.ex;
  endtask

  task automatic apply(input vec_t v, input bit push);
    sb_t item;
    @(negedge clk);
    drive(v);
    bus.start = 1'b1;
    if (push) begin
      item.v   = v;
      item.acc = cyc + 1;
      sbq.push_back(item);
      pushed++;
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && sbq.size() != 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done, pending=%0d", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mant"}, bus.mantissa_out, 64'd0);
    check({tag, "_k"}, bus.k_final, 64'd0);
    check({tag, "_exp"}, bus.exp_final, 64'd0);
    check({tag, "_sign"}, bus.sign_final, 64'd0);
    check({tag, "_inexact"}, bus.inexact, 64'd0);
    check({tag, "_overflow"}, bus.overflow, 64'd0);
    check({tag, "_busy"}, bus.busy, 64'd0);
    check({tag, "_done"}, bus.done, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 64'h4000_0000_0000_0000,  6'sd0,  1'b0, 3'd5, 32'h0000_0000,  6'sd0,  3'd5, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF,  6'sd3,  1'b0, 3'd2, 32'hFFFF_FE00,  6'sd3,  3'd2, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF,  6'sd3,  1'b1, 3'd7, 32'h0000_0000,  6'sd4,  3'd0, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 64'h4000_0008_0000_0000,  6'sd0,  1'b0, 3'd1, 32'h0000_0000,  6'sd0,  3'd1, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 64'h4000_0018_0000_0000,  6'sd0,  1'b0, 3'd1, 32'h0000_0080,  6'sd0,  3'd1, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 64'h6000_0000_0000_0001,  6'sd30, 1'b1, 3'd7, 32'h0000_0000,  6'sd30, 3'd7, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 64'h6000_0000_0000_0001, -6'sd28, 1'b0, 3'd7, 32'h0000_0000, -6'sd27, 3'd0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 64'h4000_0000_0000_0000, -6'sd28, 1'b0, 3'd3, 32'h0000_0000, -6'sd28, 3'd3, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 64'h4000_0100_0000_0001,  6'sd5,  1'b0, 3'd4, 32'h0000_0800,  6'sd5,  3'd4, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 64'h4000_0100_0000_0001,  6'sd5,  1'b0, 3'd4, 32'h0000_0000,  6'sd5,  3'd4, 1'b1, 1'b0};
    vt[10] = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF,  6'sd0,  1'b0, 3'd3, 32'h0000_0000,  6'sd0,  3'd4, 1'b1, 1'b0};
    vt[11] = '{1'b1, 64'h5555_5555_5555_5555, -6'sd1,  1'b0, 3'd6, 32'h5555_5540, -6'sd1,  3'd6, 1'b1, 1'b0};
    vt[12] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, -6'sd31, 1'b1, 3'd0, 32'h0000_0000, -6'sd31, 3'd0, 1'b1, 1'b0};
    vt[13] = '{1'b1, 64'h6000_0000_0000_0000,  6'sd30, 1'b0, 3'd2, 32'h0000_0000,  6'sd30, 3'd2, 1'b1, 1'b0};
    vt[14] = '{1'b1, 64'h6000_0000_0000_0001,  6'sd27, 1'b0, 3'd7, 32'h0000_0000,  6'sd28, 3'd0, 1'b1, 1'b0};

    bus.start = 1'b0;
    drive(vt[0]);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(vt[i], 1'b1);
      wait_empty(20);
    end

    // Busy profile, inputs scrambled after capture, start pulses while busy (incl. DONE state)
    apply(vt[8], 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("busy_window", bus.busy, 1'b1);
      check("done_early", bus.done, 1'b0);
      bus.start            = (i == 1 || i == 3);
      bus.shifted_mantissa = {$urandom, $urandom};
      bus.k_out            = 6'($urandom_range(0, 20));
      bus.exp_out          = 3'($urandom);
      bus.rnd_mode         = 1'($urandom);
      bus.sign_out         = 1'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_empty(20);
    repeat (3) @(negedge clk);
    check("hold_mantissa", bus.mantissa_out, vt[8].e_mant);
    check("hold_busy", bus.busy, 1'b0);

    // Reset while in ROUND: abort without done, then a fresh run completes
    apply(vt[1], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midreset_no_done", bus.done, 1'b0);
    end
    rst_n = 1'b1;
    apply(vt[4], 1'b1);
    wait_empty(20);

    repeat (4) @(negedge clk);
    check("done_count", 64'(done_cnt), 64'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
